br_stack_ckpt: RTL and testbench
================================

Name: br_stack_ckpt

Overview:
Parametrised branch checkpoint stack with BR_DEPTH slots.
- Allocates one slot per dispatched branch and snapshots the map table (with ready bits), the free-list head and the LSQ pointer into it.
- Keeps ready bits in live snapshots current from CDB_NUM result buses.
- On a correct resolve, frees the slot. On a mispredict, frees the slot and all younger slots and replays the snapshot to the rename stage.
- Sits between dispatch/rename and the branch-resolution path; its branch mask tags every in-flight instruction.

Parameters:
BR_DEPTH, 4, number of checkpoint slots and branch-mask width
MT_NUM, 32, architectural map-table entries
PRF_IDX_W, 6, physical register tag width
FL_PTR_W, 5, free-list pointer width (head stored as FL_PTR_W+1 bits, wrap bit included)
LSQ_P_W, 3, LSQ tail pointer width
CDB_NUM, 2, number of CDB broadcast channels

Ports:
clk  in  1  clock
rst  in  1  reset
br_disp_i  in  1  dispatch a branch this cycle
bak_mt_i  in  MT_NUM x (PRF_IDX_W+1)  next-state map table; MSB of each entry is the ready bit
bak_fl_head_i  in  FL_PTR_W+1  free-list head to checkpoint
bak_lsq_p_i  in  LSQ_P_W  LSQ pointer to checkpoint
br_mask_o  out  BR_DEPTH  current outstanding-branch mask
alloc_bit_o  out  BR_DEPTH  one-hot slot granted this cycle (zero if none)
full_o  out  1  all slots occupied
rs_vld_i  in  1  branch resolution valid
rs_bit_i  in  BR_DEPTH  one-hot slot being resolved
rs_wrong_i  in  1  1 = mispredicted, 0 = correct
cdb_vld_i  in  CDB_NUM  per-channel valid
cdb_tag_i  in  CDB_NUM x PRF_IDX_W  per-channel tag
rc_vld_o  out  1  recovery data valid
rc_mt_o  out  MT_NUM x (PRF_IDX_W+1)  recovered map table
rc_fl_head_o  out  FL_PTR_W+1  recovered free-list head
rc_lsq_p_o  out  LSQ_P_W  recovered LSQ pointer
rc_mask_o  out  BR_DEPTH  branch mask in force after recovery

Behaviour:
- Reset (rst, synchronous, active-high; clock clk): mask, all slot dependency masks, all snapshots, rc_* outputs and rc_vld_o go to 0.
- Each slot k holds a snapshot plus dep_mask[k], which is br_mask at allocation time (the older branches k depends on).
- full_o is the AND of all mask bits. It is combinational from registered state.
- Allocation (combinational grant, registered effect):
  - When br_disp_i=1, !full_o and not a wrong-resolve cycle, alloc_bit_o is the lowest-index 0 bit of the pre-update mask.
  - Next cycle that bit is 1 in br_mask_o.
  - The slot captures bak_* plus dep_mask = pre-update mask with any same-cycle correct-resolve bit cleared.
  - Otherwise alloc_bit_o = 0. A dispatch while full is dropped; upstream must stall on full_o.
- CDB update: every cycle, for every occupied slot and every valid channel c, each map entry whose tag equals cdb_tag_i[c] gets its ready bit set. The capture path applies the same update to bak_mt_i, so a same-cycle broadcast is never lost.
- Correct resolve (rs_vld_i=1, rs_wrong_i=0): clear the rs_bit_i bit in the mask and in every dep_mask. A slot freed this cycle is not re-grantable until the next cycle. Combining it with allocation in the same cycle is legal.
- Wrong resolve (rs_vld_i=1, rs_wrong_i=1) at slot k:
  - Next mask = dep_mask[k]. This frees k and every younger slot.
  - Dispatch that cycle is ignored.
  - In the next cycle rc_vld_o=1, with rc_mt_o = slot k snapshot (including same-cycle CDB updates), rc_fl_head_o, rc_lsq_p_o, and rc_mask_o = dep_mask[k].
  - rc_vld_o is a single-cycle pulse.
- Resolve naming an unoccupied slot, or a non-one-hot rs_bit_i: ignored, no state change. This is an assertion target.
- Recovery latency is exactly 1 cycle. Allocation visibility is 1 cycle.
- rst asserted mid-recovery: rc_vld_o=0 in the following cycle.

Decomposition:
- Shared package br_stack_pkg: the mt_entry_t typedef (ready + tag), the ckpt_t struct (map table, fl head, lsq pointer) and width constants, so rename and the LSQ use the same types.
- One sub-module, br_ckpt_slot, instantiated BR_DEPTH times. It handles capture enable, per-entry multi-channel CDB ready-set, and dep_mask bit-clear.
- The top level keeps the mask, the priority allocator and the recovery mux/register.

Test Plan:
- Reset, then 4 dispatches in consecutive cycles -> alloc_bit_o 0001, 0010, 0100, 1000; br_mask_o=1111, full_o=1; a 5th dispatch gives alloc_bit_o=0000.
- Mask 0111, correct resolve 0010 with dispatch in the same cycle -> alloc_bit_o=1000; next-cycle mask=1101; slot 3 dep_mask=0101.
- Slots 0,1,2 allocated in order, wrong resolve 0010 -> next cycle rc_vld_o=1, rc_mask_o=0001, br_mask_o=0001, rc_fl_head_o = value captured at slot-1 allocation.
- Slot 0 snapshot has entry 5 = tag 17 not ready; CDB channel 1 broadcasts 17 -> a subsequent wrong resolve of slot 0 returns entry 5 with ready=1.
- Dispatch with bak entry 3 = tag 9 not ready while CDB channel 0 broadcasts 9 the same cycle -> stored snapshot entry 3 has ready=1.
- Wrong resolve then rst the next cycle -> rc_vld_o=0, br_mask_o=0000.

Source files
------------

// File: rtl/br_stack_pkg.sv
// Shared branch-checkpoint types: map entry, map table, checkpoint.
// Also holds the CDB wake-up helper used on stored and captured maps.
package br_stack_pkg;
  localparam int BR_DEPTH  = 4;
  localparam int MT_NUM    = 32;
  localparam int PRF_IDX_W = 6;
  localparam int FL_PTR_W  = 5;
  localparam int LSQ_P_W   = 3;
  localparam int CDB_NUM   = 2;

  typedef logic [BR_DEPTH-1:0]  br_mask_t;
  typedef logic [PRF_IDX_W-1:0] prf_tag_t;
  typedef logic [FL_PTR_W:0]    fl_ptr_t;
  typedef logic [LSQ_P_W-1:0]   lsq_ptr_t;
  typedef logic [CDB_NUM-1:0]   cdb_vld_t;

  typedef struct packed {
    logic     rdy;
    prf_tag_t tag;
  } mt_entry_t;

  typedef mt_entry_t [MT_NUM-1:0] mt_t;
  typedef prf_tag_t [CDB_NUM-1:0] cdb_tag_t;

  typedef struct packed {
    mt_t      mt;
    fl_ptr_t  fl_head;
    lsq_ptr_t lsq_p;
  } ckpt_t;

  function automatic mt_t cdb_wake(
    mt_t      mt,
    cdb_vld_t vld,
    cdb_tag_t tag
  );
    mt_t r;
    r = mt;
    for (int e = 0; e < MT_NUM; e++)
      for (int c = 0; c < CDB_NUM; c++)
        if (vld[c] && mt[e].tag == tag[c])
          r[e].rdy = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/br_stack_ckpt_if.sv
// Dispatch, resolve, CDB and recovery bundle of the checkpoint stack.
// master = rename/resolve side, slave = the stack.
interface br_stack_ckpt_if;
  import br_stack_pkg::*;

  logic     br_disp_i;
  mt_t      bak_mt_i;
  fl_ptr_t  bak_fl_head_i;
  lsq_ptr_t bak_lsq_p_i;
  br_mask_t br_mask_o;
  br_mask_t alloc_bit_o;
  logic     full_o;
  logic     rs_vld_i;
  br_mask_t rs_bit_i;
  logic     rs_wrong_i;
  cdb_vld_t cdb_vld_i;
  cdb_tag_t cdb_tag_i;
  logic     rc_vld_o;
  mt_t      rc_mt_o;
  fl_ptr_t  rc_fl_head_o;
  lsq_ptr_t rc_lsq_p_o;
  br_mask_t rc_mask_o;

  modport master (
    output br_disp_i, bak_mt_i,
    output bak_fl_head_i, bak_lsq_p_i,
    output rs_vld_i, rs_bit_i, rs_wrong_i,
    output cdb_vld_i, cdb_tag_i,
    input  br_mask_o, alloc_bit_o, full_o,
    input  rc_vld_o, rc_mt_o, rc_fl_head_o,
    input  rc_lsq_p_o, rc_mask_o
  );

  modport slave (
    input  br_disp_i, bak_mt_i,
    input  bak_fl_head_i, bak_lsq_p_i,
    input  rs_vld_i, rs_bit_i, rs_wrong_i,
    input  cdb_vld_i, cdb_tag_i,
    output br_mask_o, alloc_bit_o, full_o,
    output rc_vld_o, rc_mt_o, rc_fl_head_o,
    output rc_lsq_p_o, rc_mask_o
  );
endinterface

// File: rtl/br_ckpt_slot.sv
// One checkpoint slot: snapshot + dependency mask, CDB wake-up.
// ckpt_nx_o exposes the post-wake value so recovery sees same-cycle CDB.
module br_ckpt_slot
  import br_stack_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     cap_i,
  input  logic     occ_i,
  input  ckpt_t    bak_i,
  input  br_mask_t dep_i,
  input  br_mask_t clr_i,
  input  cdb_vld_t cdb_vld_i,
  input  cdb_tag_t cdb_tag_i,
  output ckpt_t    ckpt_o,
  output ckpt_t    ckpt_nx_o,
  output br_mask_t dep_o
);
  ckpt_t src;

  always_comb begin
    src       = cap_i ? bak_i : ckpt_o;
    ckpt_nx_o = src;
    if (cap_i || occ_i)
      ckpt_nx_o.mt = cdb_wake(src.mt, cdb_vld_i, cdb_tag_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ckpt_o <= '0;
      dep_o  <= '0;
    end else begin
      ckpt_o <= ckpt_nx_o;
      dep_o  <= cap_i ? dep_i : (dep_o & ~clr_i);
    end
  end
endmodule

// File: rtl/br_stack_ckpt.sv
// Branch checkpoint stack: mask, lowest-free allocator, recovery register.
// Ports: clk, rst (sync, active-high), bus (br_stack_ckpt_if.slave).
module br_stack_ckpt
  import br_stack_pkg::*;
(
  input logic clk,
  input logic rst,
  br_stack_ckpt_if.slave bus
);
  br_mask_t mask, mask_nx, grant, clr, dep_keep, dep_k;
  br_mask_t dep [BR_DEPTH];
  ckpt_t    ck [BR_DEPTH];
  ckpt_t    ck_nx [BR_DEPTH];
  ckpt_t    ck_k, bak;
  logic     rs_ok, bad, good;

  logic     rc_vld;
  ckpt_t    rc_ck;
  br_mask_t rc_mask;

  assign bak = '{mt:      bus.bak_mt_i,
                 fl_head: bus.bak_fl_head_i,
                 lsq_p:   bus.bak_lsq_p_i};

  // Resolves naming a free slot or several slots are dropped.
  assign rs_ok = bus.rs_vld_i
              && $onehot(bus.rs_bit_i)
              && |(bus.rs_bit_i & mask);
  assign bad  = rs_ok &&  bus.rs_wrong_i;
  assign good = rs_ok && !bus.rs_wrong_i;
  assign clr  = good ? bus.rs_bit_i : '0;

  assign bus.full_o = &mask;

  // Lowest zero bit of the pre-update mask.
  assign grant = (bus.br_disp_i && !bus.full_o && !bad)
               ? (~mask & (mask + br_mask_t'(1))) : '0;
  assign bus.alloc_bit_o = grant;
  assign dep_keep = mask & ~clr;

  always_comb begin
    dep_k = '0;
    ck_k  = '0;
    for (int i = 0; i < BR_DEPTH; i++)
      if (bus.rs_bit_i[i]) begin
        dep_k = dep_k | dep[i];
        ck_k  = ck_k | ck_nx[i];
      end
  end

  assign mask_nx = bad ? dep_k : (dep_keep | grant);

  for (genvar i = 0; i < BR_DEPTH; i++) begin : g_slot
    br_ckpt_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .cap_i     (grant[i]),
      .occ_i     (mask[i]),
      .bak_i     (bak),
      .dep_i     (dep_keep),
      .clr_i     (clr),
      .cdb_vld_i (bus.cdb_vld_i),
      .cdb_tag_i (bus.cdb_tag_i),
      .ckpt_o    (ck[i]),
      .ckpt_nx_o (ck_nx[i]),
      .dep_o     (dep[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask    <= '0;
      rc_vld  <= 1'b0;
      rc_ck   <= '0;
      rc_mask <= '0;
    end else begin
      mask   <= mask_nx;
      rc_vld <= bad;
      if (bad) begin
        rc_ck   <= ck_k;
        rc_mask <= dep_k;
      end
    end
  end

  assign bus.br_mask_o    = mask;
  assign bus.rc_vld_o     = rc_vld;
  assign bus.rc_mt_o      = rc_ck.mt;
  assign bus.rc_fl_head_o = rc_ck.fl_head;
  assign bus.rc_lsq_p_o   = rc_ck.lsq_p;
  assign bus.rc_mask_o    = rc_mask;
endmodule

// File: tb/tb_br_stack_ckpt.sv
// Bench for br_stack_ckpt: directed scenarios plus random traffic
// checked against a slot-array reference model.
module tb_br_stack_ckpt;
  import br_stack_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  br_stack_ckpt_if bus ();

  br_stack_ckpt dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stimulus for the next cycle
  logic       s_rst, s_disp, s_rs_vld, s_wrong;
  logic [3:0] s_rs_bit;
  logic [1:0] s_cvld;
  logic [5:0] s_ctag [2];
  logic [6:0] s_bmt [32];
  logic [5:0] s_bfl;
  logic [2:0] s_blsq;

  // reference model
  bit         m_occ [4];
  bit         m_dep [4][4];
  logic [6:0] m_mt [4][32];
  logic [5:0] m_fl [4];
  logic [2:0] m_lsq [4];

  logic [3:0] e_alloc, o_alloc;
  logic       e_full, o_full;
  logic       e_rc_vld;
  logic [6:0] e_rc_mt [32];
  logic [5:0] e_rc_fl;
  logic [2:0] e_rc_lsq;
  logic [3:0] e_rc_mask;

  function automatic logic [3:0] model_mask();
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = m_occ[i];
    return m;
  endfunction

  function automatic logic [6:0] wake(logic [6:0] ent);
    logic [6:0] r;
    r = ent;
    for (int c = 0; c < 2; c++)
      if (s_cvld[c] && ent[5:0] == s_ctag[c]) r[6] = 1'b1;
    return r;
  endfunction

  function automatic mt_t exp_mt();
    mt_t r;
    for (int e = 0; e < 32; e++) r[e] = e_rc_mt[e];
    return r;
  endfunction

  task automatic rand_bak();
    for (int e = 0; e < 32; e++)
      s_bmt[e] = {1'($urandom_range(0, 1)), 6'($urandom_range(0, 15))};
    s_bfl  = 6'($urandom);
    s_blsq = 3'($urandom);
  endtask

  task automatic idle_inputs();
    s_rst = 0; s_disp = 0; s_rs_vld = 0; s_wrong = 0;
    s_rs_bit = '0; s_cvld = '0;
    s_ctag[0] = '0; s_ctag[1] = '0;
  endtask

  task automatic tick();
    int k, g, n;
    bit hit, bad, good;
    @(negedge clk);
    rst = s_rst;
    bus.br_disp_i = s_disp;
    for (int e = 0; e < 32; e++) bus.bak_mt_i[e] = s_bmt[e];
    bus.bak_fl_head_i = s_bfl;
    bus.bak_lsq_p_i   = s_blsq;
    bus.rs_vld_i   = s_rs_vld;
    bus.rs_bit_i   = s_rs_bit;
    bus.rs_wrong_i = s_wrong;
    bus.cdb_vld_i  = s_cvld;
    bus.cdb_tag_i[0] = s_ctag[0];
    bus.cdb_tag_i[1] = s_ctag[1];
    #1;
    o_alloc = bus.alloc_bit_o;
    o_full  = bus.full_o;
    e_full = (model_mask() == 4'hF);
    n = $countones(s_rs_bit);
    k = 0;
    for (int i = 0; i < 4; i++) if (s_rs_bit[i]) k = i;
    hit  = s_rs_vld && n == 1 && m_occ[k];
    bad  = hit && s_wrong;
    good = hit && !s_wrong;
    g = -1;
    if (s_disp && !e_full && !bad)
      for (int i = 3; i >= 0; i--) if (!m_occ[i]) g = i;
    e_alloc = (g >= 0) ? 4'(1 << g) : 4'h0;
    for (int i = 0; i < 4; i++)
      if (m_occ[i])
        for (int e = 0; e < 32; e++) m_mt[i][e] = wake(m_mt[i][e]);
    e_rc_vld = bad;
    if (bad) begin
      for (int e = 0; e < 32; e++) e_rc_mt[e] = m_mt[k][e];
      e_rc_fl  = m_fl[k];
      e_rc_lsq = m_lsq[k];
      for (int i = 0; i < 4; i++) e_rc_mask[i] = m_dep[k][i];
      for (int i = 0; i < 4; i++) m_occ[i] = m_dep[k][i];
    end else begin
      if (good) begin
        m_occ[k] = 0;
        for (int i = 0; i < 4; i++) m_dep[i][k] = 0;
      end
      if (g >= 0) begin
        for (int e = 0; e < 32; e++) m_mt[g][e] = wake(s_bmt[e]);
        m_fl[g]  = s_bfl;
        m_lsq[g] = s_blsq;
        for (int i = 0; i < 4; i++) m_dep[g][i] = m_occ[i];
        m_occ[g] = 1;
      end
    end
    if (s_rst) begin
      for (int i = 0; i < 4; i++) begin
        m_occ[i] = 0;
        for (int j = 0; j < 4; j++) m_dep[i][j] = 0;
      end
      e_rc_vld = 0;
    end
    @(posedge clk);
    #1;
    idle_inputs();
    rand_bak();
  endtask

  task automatic do_reset();
    s_rst = 1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.br_mask_o !== 4'h0) begin
      errors++;
      $display("FAIL reset_mask got %h want 0", bus.br_mask_o);
    end
    checks++;
    if (bus.rc_vld_o !== 1'b0 || bus.full_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got vld=%b full=%b want 0 0",
               bus.rc_vld_o, bus.full_o);
    end
    checks++;
    if (bus.rc_mt_o !== '0 || bus.rc_fl_head_o !== '0
        || bus.rc_mask_o !== '0) begin
      errors++;
      $display("FAIL reset_rc got fl=%h mask=%h want 0 0",
               bus.rc_fl_head_o, bus.rc_mask_o);
    end
  endtask

  task automatic test_fill();
    logic [3:0] want;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s_disp = 1;
      tick();
      want = 4'(1 << i);
      checks++;
      if (o_alloc !== want) begin
        errors++;
        $display("FAIL fill_alloc%0d got %b want %b", i, o_alloc, want);
      end
    end
    checks++;
    if (bus.br_mask_o !== 4'hF || bus.full_o !== 1'b1) begin
      errors++;
      $display("FAIL fill_full got mask=%b full=%b want 1111 1",
               bus.br_mask_o, bus.full_o);
    end
    s_disp = 1;
    tick();
    checks++;
    if (o_alloc !== 4'h0 || bus.br_mask_o !== 4'hF) begin
      errors++;
      $display("FAIL fill_drop got alloc=%b mask=%b want 0000 1111",
               o_alloc, bus.br_mask_o);
    end
  endtask

  task automatic test_alloc_resolve();
    do_reset();
    repeat (3) begin s_disp = 1; tick(); end
    s_disp = 1; s_rs_vld = 1; s_rs_bit = 4'b0010; s_wrong = 0;
    tick();
    checks++;
    if (o_alloc !== 4'b1000) begin
      errors++;
      $display("FAIL ar_alloc got %b want 1000", o_alloc);
    end
    checks++;
    if (bus.br_mask_o !== 4'b1101) begin
      errors++;
      $display("FAIL ar_mask got %b want 1101", bus.br_mask_o);
    end
    s_rs_vld = 1; s_rs_bit = 4'b1000; s_wrong = 1;
    tick();
    checks++;
    if (bus.rc_vld_o !== 1'b1 || bus.rc_mask_o !== 4'b0101) begin
      errors++;
      $display("FAIL ar_dep got vld=%b mask=%b want 1 0101",
               bus.rc_vld_o, bus.rc_mask_o);
    end
  endtask

  task automatic test_wrong_resolve();
    logic [5:0] fl1;
    do_reset();
    fl1 = 6'h2B;
    s_disp = 1; s_bfl = 6'h11; tick();
    s_disp = 1; s_bfl = fl1;   tick();
    s_disp = 1; s_bfl = 6'h07; tick();
    s_rs_vld = 1; s_rs_bit = 4'b0010; s_wrong = 1;
    tick();
    checks++;
    if (bus.rc_vld_o !== 1'b1 || bus.rc_mask_o !== 4'b0001
        || bus.br_mask_o !== 4'b0001) begin
      errors++;
      $display("FAIL wr_mask got vld=%b rc=%b mask=%b want 1 0001 0001",
               bus.rc_vld_o, bus.rc_mask_o, bus.br_mask_o);
    end
    checks++;
    if (bus.rc_fl_head_o !== fl1) begin
      errors++;
      $display("FAIL wr_fl got %h want %h", bus.rc_fl_head_o, fl1);
    end
    checks++;
    if (bus.rc_mt_o !== exp_mt() || bus.rc_lsq_p_o !== e_rc_lsq) begin
      errors++;
      $display("FAIL wr_snap got lsq=%h want lsq=%h (map differs?)",
               bus.rc_lsq_p_o, e_rc_lsq);
    end
    tick();
    checks++;
    if (bus.rc_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL wr_pulse got %b want 0", bus.rc_vld_o);
    end
  endtask

  task automatic test_cdb_snapshot();
    logic [6:0] got;
    do_reset();
    s_disp = 1; s_bmt[5] = {1'b0, 6'd17};
    tick();
    s_cvld = 2'b10; s_ctag[0] = 6'd3; s_ctag[1] = 6'd17;
    tick();
    s_rs_vld = 1; s_rs_bit = 4'b0001; s_wrong = 1;
    tick();
    got = bus.rc_mt_o[5];
    checks++;
    if (got !== {1'b1, 6'd17}) begin
      errors++;
      $display("FAIL cdb_snap got %h want %h", got, {1'b1, 6'd17});
    end
  endtask

  task automatic test_cdb_capture();
    logic [6:0] got;
    do_reset();
    s_disp = 1; s_bmt[3] = {1'b0, 6'd9};
    s_cvld = 2'b01; s_ctag[0] = 6'd9; s_ctag[1] = 6'd40;
    tick();
    s_rs_vld = 1; s_rs_bit = 4'b0001; s_wrong = 1;
    tick();
    got = bus.rc_mt_o[3];
    checks++;
    if (got !== {1'b1, 6'd9}) begin
      errors++;
      $display("FAIL cdb_cap got %h want %h", got, {1'b1, 6'd9});
    end
    checks++;
    if (bus.rc_mt_o !== exp_mt()) begin
      errors++;
      $display("FAIL cdb_cap_map got %h want %h",
               bus.rc_mt_o, exp_mt());
    end
  endtask

  task automatic test_bad_resolve();
    do_reset();
    repeat (2) begin s_disp = 1; tick(); end
    s_rs_vld = 1; s_rs_bit = 4'b0011; s_wrong = 1;
    tick();
    checks++;
    if (bus.br_mask_o !== 4'b0011 || bus.rc_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL bad_multi got mask=%b vld=%b want 0011 0",
               bus.br_mask_o, bus.rc_vld_o);
    end
    s_rs_vld = 1; s_rs_bit = 4'b0100; s_wrong = 1;
    tick();
    checks++;
    if (bus.br_mask_o !== 4'b0011 || bus.rc_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL bad_free got mask=%b vld=%b want 0011 0",
               bus.br_mask_o, bus.rc_vld_o);
    end
  endtask

  task automatic test_reset_mid_recovery();
    do_reset();
    repeat (2) begin s_disp = 1; tick(); end
    s_rs_vld = 1; s_rs_bit = 4'b0010; s_wrong = 1;
    tick();
    checks++;
    if (bus.rc_vld_o !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pulse got %b want 1", bus.rc_vld_o);
    end
    s_rst = 1;
    tick();
    checks++;
    if (bus.rc_vld_o !== 1'b0 || bus.br_mask_o !== 4'h0) begin
      errors++;
      $display("FAIL rmid_rst got vld=%b mask=%b want 0 0000",
               bus.rc_vld_o, bus.br_mask_o);
    end
  endtask

  task automatic test_random();
    logic [3:0] m;
    int b;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      m = model_mask();
      s_disp = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 9) < 4) begin
        s_rs_vld = 1;
        s_wrong  = ($urandom_range(0, 9) < 3);
        b = $urandom_range(0, 3);
        if ($urandom_range(0, 9) == 0) s_rs_bit = 4'($urandom);
        else if (m != 0) begin
          while (!m[b]) b = (b + 1) % 4;
          s_rs_bit = 4'(1 << b);
        end else s_rs_bit = 4'(1 << b);
      end
      s_cvld = 2'($urandom);
      s_ctag[0] = 6'($urandom_range(0, 15));
      s_ctag[1] = 6'($urandom_range(0, 15));
      tick();
      checks++;
      if (o_alloc !== e_alloc || o_full !== e_full) begin
        errors++;
        $display("FAIL rnd_alloc n=%0d got %b/%b want %b/%b",
                 n, o_alloc, o_full, e_alloc, e_full);
      end
      checks++;
      if (bus.br_mask_o !== model_mask()
          || bus.rc_vld_o !== e_rc_vld) begin
        errors++;
        $display("FAIL rnd_mask n=%0d got %b/%b want %b/%b",
                 n, bus.br_mask_o, bus.rc_vld_o,
                 model_mask(), e_rc_vld);
      end
      if (e_rc_vld) begin
        checks++;
        if (bus.rc_mt_o !== exp_mt()
            || bus.rc_fl_head_o !== e_rc_fl
            || bus.rc_lsq_p_o !== e_rc_lsq
            || bus.rc_mask_o !== e_rc_mask) begin
          errors++;
          $display("FAIL rnd_rc n=%0d got fl=%h lsq=%h m=%b want %h %h %b",
                   n, bus.rc_fl_head_o, bus.rc_lsq_p_o,
                   bus.rc_mask_o, e_rc_fl, e_rc_lsq, e_rc_mask);
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    rand_bak();
    test_reset();
    test_fill();
    test_alloc_resolve();
    test_wrong_resolve();
    test_cdb_snapshot();
    test_cdb_capture();
    test_bad_resolve();
    test_reset_mid_recovery();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
